// File: rtl/uart_mini_rx.sv
// APB-slave 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, small receive FIFO.
// Optional break detection is enabled with `define UART_RX_BREAK_DETECT_EN.
module uart_mini_rx #(
  parameter int unsigned CLKS_PER_BIT    = 434,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        apbs_psel,
  input  logic        apbs_penable,
  input  logic        apbs_pwrite,
  input  logic [15:0] apbs_paddr,
  input  logic [31:0] apbs_pwdata,
  output logic [31:0] apbs_prdata,
  output logic        apbs_pready,
  output logic        apbs_pslverr,
  input  logic        rx,
  output logic        rts,
  output logic        irq,
  output logic        dreq
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W = FIFO_DEPTH_LOG2;
  localparam int unsigned OCC_W = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
`ifdef UART_RX_BREAK_DETECT_EN
  localparam logic [2:0] S_BRKWAIT = 3'd4;
`endif

  logic             rx_meta, rxs;
  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             push_c;
  logic [8:0]       push_data_c;

  logic [8:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] count, count_nxt;
  logic             nonempty, full;
  logic [8:0]       head;

  logic             access_c, rd_c, wr_c, pop_c, wr_en_c, ovr_set_c;
  logic [1:0]       reg_sel;
  logic             ovr, ovr_nxt, ie, ie_nxt, brk, brk_nxt;
  logic             unused_bits;

  // Two-flop synchroniser; idles high so reset cannot fake a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic brk_set_c;
`endif

  // Receive sequencing: half-bit delay to centre on the start bit, then one bit per reload.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    push_c    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    brk_set_c = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_nxt = S_START;
          cnt_nxt   = HALF_RELOAD;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          if (rxs) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
            bit_nxt   = 3'd0;
            cnt_nxt   = BIT_RELOAD;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          shift_nxt = {rxs, shift[7:1]};
          cnt_nxt   = BIT_RELOAD;
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          state_nxt = S_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
          if (!rxs && (shift == 8'h00)) begin
            brk_set_c = 1'b1;
            state_nxt = S_BRKWAIT;
          end else begin
            push_c = 1'b1;
          end
`else
          push_c = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
`ifdef UART_RX_BREAK_DETECT_EN
      S_BRKWAIT: begin
        if (rxs) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  assign push_data_c = {~rxs, shift};

  // APB decode and FIFO control; a push into a full FIFO only lands if a pop frees a slot.
  assign access_c  = apbs_psel & apbs_penable;
  assign rd_c      = access_c & ~apbs_pwrite;
  assign wr_c      = access_c & apbs_pwrite;
  assign reg_sel   = apbs_paddr[3:2];
  assign nonempty  = (count != '0);
  assign full      = (count == OCC_W'(DEPTH));
  assign head      = mem[rd_ptr];
  assign pop_c     = rd_c & (reg_sel == 2'd0) & nonempty;
  assign wr_en_c   = push_c & (~full | pop_c);
  assign ovr_set_c = push_c & full & ~pop_c;

  always_comb begin
    count_nxt = count;
    if (wr_en_c && !pop_c) count_nxt = count + OCC_W'(1);
    else if (!wr_en_c && pop_c) count_nxt = count - OCC_W'(1);
  end

  always_comb begin
    ovr_nxt = ovr;
    if (ovr_set_c) ovr_nxt = 1'b1;
    else if (wr_c && (reg_sel == 2'd1) && apbs_pwdata[2]) ovr_nxt = 1'b0;
  end

`ifdef UART_RX_BREAK_DETECT_EN
  always_comb begin
    brk_nxt = brk;
    if (brk_set_c) brk_nxt = 1'b1;
    else if (wr_c && (reg_sel == 2'd1) && apbs_pwdata[3]) brk_nxt = 1'b0;
  end
  assign unused_bits = ^{apbs_paddr[15:4], apbs_paddr[1:0], apbs_pwdata[31:4], apbs_pwdata[1]};
`else
  assign brk_nxt     = 1'b0;
  assign unused_bits = ^{apbs_paddr[15:4], apbs_paddr[1:0], apbs_pwdata[31:3], apbs_pwdata[1]};
`endif

  assign ie_nxt = (wr_c && (reg_sel == 2'd2)) ? apbs_pwdata[0] : ie;

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr] <= push_data_c;
  end

  // Status outputs are registered from next-state values so they track occupancy without lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
      ie     <= 1'b0;
      brk    <= 1'b0;
      rts    <= 1'b1;
      irq    <= 1'b0;
      dreq   <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)   rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      ovr   <= ovr_nxt;
      ie    <= ie_nxt;
      brk   <= brk_nxt;
      rts   <= (count_nxt < OCC_W'(DEPTH - 1));
      irq   <= ie_nxt & ((count_nxt != '0) | ovr_nxt | brk_nxt);
      dreq  <= (count_nxt != '0);
    end
  end

  // Read mux; DATA comes straight from the FIFO head so the pop and the data share one access.
  always_comb begin
    apbs_prdata = '0;
    if (rd_c) begin
      case (reg_sel)
        2'd0:    if (nonempty) apbs_prdata = {22'b0, head[8], 1'b1, head[7:0]};
        2'd1:    apbs_prdata = {28'b0, brk, ovr, full, nonempty};
        2'd2:    apbs_prdata = {31'b0, ie};
        default: apbs_prdata = '0;
      endcase
    end
  end

  assign apbs_pready  = 1'b1;
  assign apbs_pslverr = 1'b0;

endmodule

// File: tb/tb_uart_mini_rx.sv
// Self-checking bench for uart_mini_rx: register table, directed frame sequences,
// and random frames checked against a queue-based model of the receive FIFO.
module tb_uart_mini_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned DLOG = 2;
  localparam int unsigned DEPTH = 1 << DLOG;

  localparam logic [15:0] A_DATA = 16'h0;
  localparam logic [15:0] A_STAT = 16'h4;
  localparam logic [15:0] A_CTRL = 16'h8;
  localparam logic [15:0] A_R3   = 16'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        rx, rts, irq, dreq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_mini_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DLOG)) dut (
    .clk(clk), .rst_n(rst_n),
    .apbs_psel(psel), .apbs_penable(penable), .apbs_pwrite(pwrite),
    .apbs_paddr(paddr), .apbs_pwdata(pwdata), .apbs_prdata(prdata),
    .apbs_pready(pready), .apbs_pslverr(pslverr),
    .rx(rx), .rts(rts), .irq(irq), .dreq(dreq)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    d = prdata;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_write(input logic [15:0] a, input logic [31:0] w);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = w;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    check(name, d, exp);
  endtask

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop);
    hold_bit(1'b1);
  endtask

  function automatic logic [31:0] data_word(input logic ferr, input logic [7:0] b);
    return {22'b0, ferr, 1'b1, b};
  endfunction

  // Reference model: receive FIFO as a queue plus sticky flags.
  logic [8:0] q[$];
  logic       ovr_m, brk_m;

  task automatic model_frame(input logic [7:0] b, input logic stop);
`ifdef UART_RX_BREAK_DETECT_EN
    if (!stop && b == 8'h00) begin
      brk_m = 1'b1;
      return;
    end
`endif
    if (q.size() == DEPTH) ovr_m = 1'b1;
    else q.push_back({~stop, b});
  endtask

  function automatic logic [31:0] model_stat();
    return {28'b0, brk_m, ovr_m, q.size() == DEPTH, q.size() != 0};
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    logic        stop;
    int          nrd;

    rst_n = 1'b0; rx = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    q = {}; ovr_m = 1'b0; brk_m = 1'b0;

    tbl[0]  = '{1'b0, A_DATA, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, A_STAT, 32'h0,        32'h0};
    tbl[2]  = '{1'b0, A_CTRL, 32'h0,        32'h0};
    tbl[3]  = '{1'b0, A_R3,   32'h0,        32'h0};
    tbl[4]  = '{1'b1, A_CTRL, 32'h1,        32'h0};
    tbl[5]  = '{1'b0, A_CTRL, 32'h0,        32'h1};
    tbl[6]  = '{1'b1, A_R3,   32'hFFFF_FFFF, 32'h0};
    tbl[7]  = '{1'b0, A_R3,   32'h0,        32'h0};
    tbl[8]  = '{1'b0, A_CTRL, 32'h0,        32'h1};
    tbl[9]  = '{1'b1, A_CTRL, 32'hFFFF_FFFE, 32'h0};
    tbl[10] = '{1'b0, A_CTRL, 32'h0,        32'h0};
    tbl[11] = '{1'b0, A_STAT, 32'h0,        32'h0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_rts", 32'(rts), 32'h1);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_dreq", 32'(dreq), 32'h0);
    check("reset_prdata", prdata, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("pready", 32'(pready), 32'h1);
    check("pslverr", 32'(pslverr), 32'h0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].wdata);
      else rd_chk($sformatf("reg_tbl[%0d]", i), tbl[i].addr, tbl[i].exp);
    end

    // Good frame, then prdata must stay 0 outside an access phase.
    send_frame(8'hA5, 1'b1);
    check("a5_dreq", 32'(dreq), 32'h1);
    check("idle_prdata", prdata, 32'h0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_DATA;
    @(negedge clk);
    check("setup_prdata", prdata, 32'h0);
    @(posedge clk); #1;
    psel = 1'b0;
    rd_chk("a5_data", A_DATA, 32'h1A5);
    rd_chk("a5_empty", A_DATA, 32'h0);
    rd_chk("a5_stat", A_STAT, 32'h0);

    send_frame(8'h3C, 1'b0);
    rd_chk("ferr_data", A_DATA, 32'h33C);

    // Short low glitch is rejected; receiver still works afterwards.
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    rd_chk("glitch_stat", A_STAT, 32'h0);
    send_frame(8'h5A, 1'b1);
    rd_chk("post_glitch", A_DATA, 32'h15A);

    // Fill past capacity without reading.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      if (i == 2) check("rts_occ2", 32'(rts), 32'h1);
      if (i == 3) check("rts_occ3", 32'(rts), 32'h0);
    end
    rd_chk("ovr_stat", A_STAT, 32'h7);
    for (int i = 1; i <= 4; i++)
      rd_chk($sformatf("ovr_data%0d", i), A_DATA, data_word(1'b0, 8'(i)));
    rd_chk("ovr_stat_drained", A_STAT, 32'h4);
    check("rts_drained", 32'(rts), 32'h1);
    apb_write(A_STAT, 32'h4);
    rd_chk("ovr_cleared", A_STAT, 32'h0);

    // Interrupt behaviour.
    apb_write(A_CTRL, 32'h1);
    check("irq_idle", 32'(irq), 32'h0);
    send_frame(8'h55, 1'b1);
    check("irq_set", 32'(irq), 32'h1);
    rd_chk("irq_data", A_DATA, 32'h155);
    check("irq_clear", 32'(irq), 32'h0);

    // Pop landing in the same cycle as a push keeps occupancy constant.
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (153) @(posedge clk);
        apb_read(A_DATA, d);
        check("samecyc_data", d, 32'h111);
      end
    join
    rd_chk("samecyc_stat", A_STAT, 32'h1);
    check("samecyc_irq", 32'(irq), 32'h1);
    rd_chk("samecyc_next", A_DATA, 32'h122);
    rd_chk("samecyc_empty", A_STAT, 32'h0);
    apb_write(A_CTRL, 32'h0);

    // Long low line: break.
`ifdef UART_RX_BREAK_DETECT_EN
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (30 * CPB) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    rd_chk("brk_stat", A_STAT, 32'h8);
    rd_chk("brk_nodata", A_DATA, 32'h0);
    send_frame(8'h42, 1'b1);
    rd_chk("brk_after", A_DATA, 32'h142);
    apb_write(A_STAT, 32'h8);
    rd_chk("brk_cleared", A_STAT, 32'h0);
`else
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (10 * CPB) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    rd_chk("brk_stat", A_STAT, 32'h1);
    rd_chk("brk_data", A_DATA, 32'h300);
    rd_chk("brk_empty", A_STAT, 32'h0);
`endif

    // Random frames against the queue model.
    for (int i = 0; i < 24; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      if (!stop && $urandom_range(0, 2) == 0) b = 8'h00;
      send_frame(b, stop);
      model_frame(b, stop);
      rd_chk($sformatf("rnd%0d_stat", i), A_STAT, model_stat());
      check($sformatf("rnd%0d_rts", i), 32'(rts), 32'(q.size() < DEPTH - 1));
      check($sformatf("rnd%0d_dreq", i), 32'(dreq), 32'(q.size() != 0));
      nrd = $urandom_range(0, 2);
      for (int k = 0; k < nrd; k++) begin
        if (q.size() != 0) rd_chk($sformatf("rnd%0d_rd%0d", i, k), A_DATA, data_word(q[0][8], q[0][7:0]));
        else rd_chk($sformatf("rnd%0d_rd%0d", i, k), A_DATA, 32'h0);
        if (q.size() != 0) void'(q.pop_front());
      end
    end
    while (q.size() != 0) begin
      rd_chk("rnd_drain", A_DATA, data_word(q[0][8], q[0][7:0]));
      void'(q.pop_front());
    end
    apb_write(A_STAT, 32'hC);
    ovr_m = 1'b0; brk_m = 1'b0;
    rd_chk("rnd_final_stat", A_STAT, model_stat());

    // Reset in the middle of a frame discards it and empties the FIFO.
    send_frame(8'h77, 1'b1);
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12 * CPB) @(posedge clk);
    #1;
    check("midrst_dreq", 32'(dreq), 32'h0);
    check("midrst_rts", 32'(rts), 32'h1);
    rd_chk("midrst_stat", A_STAT, 32'h0);
    rd_chk("midrst_data", A_DATA, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
